// File: rtl/psram_bus_bridge.sv
// Bridges the CPU data-bus command/response port onto the 32-bit PSRAM word interface,
// turning byte-masked stores into full-word writes (read-modify-write when partially masked).
module psram_bus_bridge #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bus_cmd_valid,
    output logic        bus_cmd_ready,
    input  logic        bus_cmd_wr,
    input  logic [23:0] bus_cmd_addr,
    input  logic [31:0] bus_cmd_data,
    input  logic [3:0]  bus_cmd_mask,
    output logic        bus_rsp_valid,
    output logic [31:0] bus_rsp_data,
    output logic        err,
    output logic        word_rd,
    output logic        word_wr,
    output logic [21:0] word_addr,
    output logic [31:0] word_data,
    input  logic [31:0] word_q,
    input  logic        word_busy
);

    localparam int unsigned AW    = 24;
    localparam int unsigned DW    = 32;
    localparam int unsigned MW    = 4;
    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, RD_ISSUE, RD_ACK, RD_WAIT, MERGE, WR_ISSUE, WR_ACK, WR_WAIT, RESP
    } state_t;

    typedef struct packed {
        logic          wr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } cmd_t;

    state_t           state;
    cmd_t             cmd;
    logic [DW-1:0]    rdata;
    logic [DW-1:0]    merged;
    logic [CNT_W-1:0] cnt;
    logic             timeout;
    logic             unused_addr_lsbs;

    assign unused_addr_lsbs = ^bus_cmd_addr[1:0];
    assign timeout          = (cnt == CNT_W'(ACK_TIMEOUT - 1));

    // Byte-lane merge of store data over the word read back from PSRAM
    always_comb begin
        merged = rdata;
        for (int n = 0; n < int'(MW); n++) begin
            if (cmd.mask[n]) begin
                merged[8*n +: 8] = cmd.data[8*n +: 8];
            end
        end
    end

    // Request pulses are only raised while the controller is idle; ISSUE states hold until then
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cmd           <= '0;
            rdata         <= '0;
            cnt           <= '0;
            bus_cmd_ready <= 1'b0;
            bus_rsp_valid <= 1'b0;
            bus_rsp_data  <= '0;
            err           <= 1'b0;
            word_rd       <= 1'b0;
            word_wr       <= 1'b0;
            word_addr     <= '0;
            word_data     <= '0;
        end else begin
            word_rd       <= 1'b0;
            word_wr       <= 1'b0;
            bus_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    bus_cmd_ready <= !word_busy;
                    if (bus_cmd_valid && bus_cmd_ready) begin
                        cmd       <= '{wr: bus_cmd_wr, data: bus_cmd_data, mask: bus_cmd_mask};
                        word_addr <= bus_cmd_addr[AW-1:2];
                        if (!bus_cmd_wr || (bus_cmd_mask != '0 && bus_cmd_mask != '1)) begin
                            state         <= RD_ISSUE;
                            word_rd       <= !word_busy;
                            bus_cmd_ready <= 1'b0;
                        end else if (bus_cmd_mask == '1) begin
                            state         <= WR_ISSUE;
                            word_wr       <= !word_busy;
                            word_data     <= bus_cmd_data;
                            bus_cmd_ready <= 1'b0;
                        end
                    end
                end
                RD_ISSUE: begin
                    cnt <= '0;
                    if (word_rd) begin
                        state <= RD_ACK;
                    end else begin
                        word_rd <= !word_busy;
                    end
                end
                RD_ACK: begin
                    if (word_busy) begin
                        state <= RD_WAIT;
                    end else if (timeout) begin
                        // A load that never got acknowledged still answers, with zero data
                        err           <= 1'b1;
                        state         <= IDLE;
                        bus_cmd_ready <= 1'b1;
                        if (!cmd.wr) begin
                            bus_rsp_valid <= 1'b1;
                            bus_rsp_data  <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RD_WAIT: begin
                    if (!word_busy) begin
                        rdata <= word_q;
                        if (cmd.wr) begin
                            state <= MERGE;
                        end else begin
                            state         <= RESP;
                            bus_rsp_valid <= 1'b1;
                            bus_rsp_data  <= word_q;
                        end
                    end
                end
                MERGE: begin
                    word_data <= merged;
                    word_wr   <= !word_busy;
                    state     <= WR_ISSUE;
                end
                WR_ISSUE: begin
                    cnt <= '0;
                    if (word_wr) begin
                        state <= WR_ACK;
                    end else begin
                        word_wr <= !word_busy;
                    end
                end
                WR_ACK: begin
                    if (word_busy) begin
                        state <= WR_WAIT;
                    end else if (timeout) begin
                        err           <= 1'b1;
                        state         <= IDLE;
                        bus_cmd_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WR_WAIT: begin
                    if (!word_busy) begin
                        state         <= IDLE;
                        bus_cmd_ready <= 1'b1;
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    bus_cmd_ready <= !word_busy;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
